// File: rtl/rand_range_sampler_pkg.sv
// Shared definitions for the range-reduced random sampler: FSM encoding,
// default widths and the mask-from-bound helper.
package rand_range_sampler_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefOutWidth  = 8;
    // Widest bound the mask helper handles; OUT_WIDTH must not exceed it.
    localparam int unsigned MaskMaxWidth = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlush = 2'd1,
        StRun   = 2'd2
    } state_e;

    // OR-smear every set bit downwards: yields the smallest 2^k-1 >= bound.
    function automatic logic [MaskMaxWidth-1:0] mask_from_bound(
        input logic [MaskMaxWidth-1:0] bound
    );
        logic [MaskMaxWidth-1:0] m;
        m = bound;
        for (int i = MaskMaxWidth - 2; i >= 0; i--) begin
            m[i] = m[i] | m[i+1];
        end
        return m;
    endfunction

endpackage

// File: rtl/rand_range_sampler_if.sv
// Configuration, sample-in and valid/ready output bundle of the sampler.
// The sampler connects through the slave modport; its driver uses master.
interface rand_range_sampler_if
    import rand_range_sampler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned OUT_WIDTH  = DefOutWidth
);
    logic                  cfg_valid;
    logic [OUT_WIDTH-1:0]  range_max;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  overflow;
    logic [15:0]           reject_cnt;

    modport master (
        output cfg_valid, range_max, in_data, in_valid, out_ready,
        input  out_data, out_valid, overflow, reject_cnt
    );

    modport slave (
        input  cfg_valid, range_max, in_data, in_valid, out_ready,
        output out_data, out_valid, overflow, reject_cnt
    );
endinterface

// File: rtl/rand_range_sampler_sync_fifo.sv
// Small synchronous FIFO with synchronous flush. A push while full is
// accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0] FullCount = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (r_count == FullCount);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/rand_range_sampler.sv
// Range sampler: reduces LFSR words to uniform values in [0, range_max] by
// mask-and-reject and buffers accepted values for a valid/ready consumer.
// Optional macro RAND_SAMPLER_STATS_EN builds the saturating reject counter;
// without it reject_cnt is tied to zero.
module rand_range_sampler
    import rand_range_sampler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DefDataWidth,
    parameter int unsigned OUT_WIDTH       = DefOutWidth,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned LOG2_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rand_range_sampler_if.slave   bus
);
    state_e                   r_state;
    state_e                   w_state_next;
    logic [OUT_WIDTH-1:0]     r_range;
    logic [OUT_WIDTH-1:0]     r_mask;
    logic [MaskMaxWidth-1:0]  w_bound_ext;
    logic [MaskMaxWidth-1:0]  w_mask_ext;
    logic [OUT_WIDTH-1:0]     w_cand;
    logic [OUT_WIDTH-1:0]     w_fifo_rdata;
    logic                     w_flush;
    logic                     w_sample_en;
    logic                     w_out_en;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_reject;
    logic                     w_full;
    logic                     w_empty;
    logic                     r_overflow;
    logic [LOG2_FIFO_DEPTH:0] w_unused_count;

    // Widen range_max to the helper width and derive its mask.
    always_comb begin
        w_bound_ext                = '0;
        w_bound_ext[OUT_WIDTH-1:0] = bus.range_max;
        w_mask_ext                 = mask_from_bound(w_bound_ext);
    end

    if (OUT_WIDTH < MaskMaxWidth) begin : g_mask_hi
        logic w_unused_mask_hi;
        assign w_unused_mask_hi = ^w_mask_ext[MaskMaxWidth-1:OUT_WIDTH];
    end

    // Only the low OUT_WIDTH bits of the random word feed the candidate.
    if (DATA_WIDTH > OUT_WIDTH) begin : g_data_hi
        logic w_unused_data_hi;
        assign w_unused_data_hi = ^bus.in_data[DATA_WIDTH-1:OUT_WIDTH];
    end

    // Range and mask latch on any cfg_valid, whatever the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range <= '0;
            r_mask  <= '0;
        end else if (bus.cfg_valid) begin
            r_range <= bus.range_max;
            r_mask  <= w_mask_ext[OUT_WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: cfg_valid always (re)enters FLUSH.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.cfg_valid) w_state_next = StFlush;
            StFlush: w_state_next = bus.cfg_valid ? StFlush : StRun;
            StRun:   if (bus.cfg_valid) w_state_next = StFlush;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs: FLUSH clears the buffer, RUN samples and presents data.
    always_comb begin
        w_flush     = 1'b0;
        w_sample_en = 1'b0;
        w_out_en    = 1'b0;
        unique case (r_state)
            StFlush: w_flush = 1'b1;
            StRun: begin
                w_sample_en = 1'b1;
                w_out_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cand   = bus.in_data[OUT_WIDTH-1:0] & r_mask;
    assign w_accept = (w_cand <= r_range);
    assign w_push   = w_sample_en && bus.in_valid && w_accept;
    assign w_reject = w_sample_en && bus.in_valid && !w_accept;

    assign bus.out_valid = w_out_en && !w_empty;
    assign bus.out_data  = w_fifo_rdata;
    assign w_pop         = bus.out_valid && bus.out_ready;

    sync_fifo #(
        .WIDTH  (OUT_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (w_cand),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_unused_count)
    );

    // Sticky overflow: an accepted sample hit a full FIFO with no pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;

`ifdef RAND_SAMPLER_STATS_EN
    logic [15:0] r_reject_cnt;

    // Saturating count of rejected samples; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reject_cnt <= '0;
        end else if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
            r_reject_cnt <= r_reject_cnt + 16'd1;
        end
    end

    assign bus.reject_cnt = r_reject_cnt;
`else
    logic w_unused_reject;
    assign w_unused_reject = w_reject;
    assign bus.reject_cnt  = '0;
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
// Scoreboard bench for rand_range_sampler: each step drives one cycle of
// stimulus, checks the outputs against a reference queue, then advances it.
module tb_rand_range_sampler;

`ifdef RAND_SAMPLER_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    localparam int MIdle  = 0;
    localparam int MFlush = 1;
    localparam int MRun   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rand_range_sampler_if #(.DATA_WIDTH(16), .OUT_WIDTH(8)) bus ();

    rand_range_sampler #(
        .DATA_WIDTH      (16),
        .OUT_WIDTH       (8),
        .FIFO_DEPTH      (4),
        .LOG2_FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         m_state;
    logic [7:0] m_range;
    logic [7:0] m_mask;
    bit         m_ovf;
    int         m_rej;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_mask(input logic [7:0] r);
        int m;
        m = 0;
        while (m < int'(r)) m = m * 2 + 1;
        return m[7:0];
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = (m_state == MRun) && (exp_q.size() > 0);
        check_eq("out_valid", 32'(bus.out_valid), 32'(ev));
        if (ev) check_eq("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
        check_eq("reject_cnt", 32'(bus.reject_cnt), 32'(m_rej));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = MIdle;
        m_range = '0;
        m_mask  = '0;
        m_ovf   = 1'b0;
        m_rej   = 0;
    endtask

    task automatic step(input bit cfg, input logic [7:0] rmax, input bit iv,
                        input logic [15:0] d, input bit rdy);
        bit         pop;
        logic [7:0] cand;
        bus.cfg_valid = cfg;
        bus.range_max = rmax;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        @(negedge clk);
        check_outputs();
        pop = (m_state == MRun) && (exp_q.size() > 0) && rdy;
        if ((m_state == MRun) && iv) begin
            cand = d[7:0] & m_mask;
            if (cand <= m_range) begin
                if (exp_q.size() < 4 || pop) exp_q.push_back(cand);
                else m_ovf = 1'b1;
            end else if (StatsEn && m_rej < 16'hFFFF) begin
                m_rej++;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (m_state == MFlush) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end
        if (cfg) begin
            m_range = rmax;
            m_mask  = model_mask(rmax);
            m_state = MFlush;
        end else if (m_state == MFlush) begin
            m_state = MRun;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.range_max = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        check_eq("rst_out_data", 32'(bus.out_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // IDLE ignores samples.
        repeat (3) step(1'b0, 8'd0, 1'b1, 16'h1234, 1'b1);
        step(1'b0, 8'd0, 1'b1, 16'h00FF, 1'b0);

        // Range 5 (mask 7): 0x1234 -> 4 accepted, 0x0007 -> rejected.
        step(1'b1, 8'd5, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h0003, 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h0007, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);

        // Ten rejected samples.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'd0, 1'b1, (i % 2 == 0) ? 16'h0006 : 16'hFF07, 1'b1);
        end
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);

        // Full range: fill, drop a fifth sample, drain.
        step(1'b1, 8'd255, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        for (int v = 1; v <= 4; v++) step(1'b0, 8'd0, 1'b1, 16'(v), 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h0005, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        repeat (4) step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);

        // Re-flush, fill, then push+pop while full.
        step(1'b1, 8'd255, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        for (int v = 0; v < 4; v++) step(1'b0, 8'd0, 1'b1, 16'hAB10 + 16'(v), 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h0009, 1'b1);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h0077, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b1);

        // Three buffered with overflow set; reconfigure twice (FLUSH extended), range 0.
        step(1'b1, 8'd3, 1'b1, 16'h0042, 1'b0);
        step(1'b1, 8'd0, 1'b1, 16'h00FF, 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h00FF, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b1, 16'($urandom), 1'b1);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b1);

        // Random traffic with range 100 (mask 127).
        step(1'b1, 8'd100, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 8'd0, 1'($urandom_range(1, 0)), 16'($urandom),
                 1'($urandom_range(1, 0)));
        end

        // Two buffered with overflow set, then asynchronous reset.
        step(1'b1, 8'd255, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        for (int v = 1; v <= 5; v++) step(1'b0, 8'd0, 1'b1, 16'(v), 1'b0);
        repeat (2) step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_mid_ovf", 32'(bus.overflow), 32'h0);
        check_eq("rst_mid_rej", 32'(bus.reject_cnt), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back in IDLE, then normal operation resumes.
        repeat (3) step(1'b0, 8'd0, 1'b1, 16'h1234, 1'b1);
        step(1'b1, 8'd5, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 8'd0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 8'd0, 1'b0, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
- Sits directly downstream of the 16-bit LFSR random number generator.
- Consumes each random_number / random_number_valid pulse.
- Reduces the sample to a uniform value in [0, range_max] by mask-and-reject.
- Buffers accepted values in a small FIFO and presents them to the solver logic over a valid/ready interface.

Parameters:
- DATA_WIDTH, 16, width of the incoming random word.
- OUT_WIDTH, 8, width of the range-reduced output; must be <= DATA_WIDTH.
- FIFO_DEPTH, 4, number of buffered accepted samples; power of two.
- LOG2_FIFO_DEPTH, 2, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  one-cycle pulse that loads range_max.
- range_max  input  OUT_WIDTH  inclusive upper bound of the output range.
- in_data  input  DATA_WIDTH  random word (connects to random_number).
- in_valid  input  1  sample strobe (connects to random_number_valid).
- out_data  output  OUT_WIDTH  FIFO head value.
- out_valid  output  1  FIFO non-empty and state == RUN.
- out_ready  input  1  consumer accepts out_data this cycle.
- overflow  output  1  sticky: an accepted sample was dropped because the FIFO was full.
- reject_cnt  output  16  count of rejected samples (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high.
  - state=IDLE; range_reg=0, mask_reg=0; FIFO pointers and count=0.
  - out_data=0, out_valid=0, overflow=0, reject_cnt=0.
- States and transitions:
  - IDLE: range not configured; in_valid is ignored. cfg_valid -> FLUSH.
  - FLUSH: lasts exactly 1 cycle. Clears the FIFO pointers and count, and clears overflow. in_valid is ignored and out_valid=0. Goes to RUN next. If cfg_valid arrives during FLUSH: re-latch the range and stay in FLUSH for one more cycle.
  - RUN: sampling active. cfg_valid -> FLUSH; the buffered data is discarded.
- cfg_valid is honoured in any state. It latches range_reg=range_max and mask_reg=smallest 2^k-1 >= range_max (computed combinationally from range_max, registered).
- Sampling in RUN: cand = in_data[OUT_WIDTH-1:0] & mask_reg.
  - Accept if cand <= range_reg.
  - Otherwise reject: no FIFO write; reject_cnt increments.
- Boundary ranges:
  - range_max=0: mask=0, every sample is accepted as 0.
  - range_max=all-ones: every sample is accepted unmasked.
- Latency: an accepted sample is written on the edge where in_valid=1. When the FIFO was empty, out_valid=1 and out_data=cand on the following cycle (1-cycle latency).
- Handshake: a pop occurs on a cycle with out_valid && out_ready. out_data is held stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - A push with no simultaneous pop drops the sample, sets overflow=1 and leaves count unchanged.
  - A push and pop in the same cycle both succeed; count is unchanged and overflow is not set.
- Empty FIFO: out_valid=0; out_ready is ignored.
- Pointers wrap modulo FIFO_DEPTH. count has width LOG2_FIFO_DEPTH+1.
- overflow is cleared only by reset or FLUSH.
- reject_cnt saturates at 16'hFFFF and is cleared by reset only.
- Reset asserted mid-operation discards all state immediately, with no completion of a pending pop or push.

Optional Feature:
- Macro: RAND_SAMPLER_STATS_EN.
- Defined: the reject_cnt counter is implemented as described.
- Undefined: no counter register is built; reject_cnt is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package (rand_pkg) holds:
  - the state encoding constants IDLE/FLUSH/RUN;
  - the default DATA_WIDTH/OUT_WIDTH;
  - a mask-from-bound function (OR-smear of range_max).
- One sub-module: sync_fifo, a parameterised by DATA width/depth. It has push/pop/flush inputs and full/empty/count outputs, and a simultaneous push+pop when full is legal.
- The sampler top holds the FSM, mask/compare, overflow and stats logic.

Test Plan:
- cfg range_max=5 (mask 7) in RUN:
  - in_data=16'h1234 -> cand=4, out_valid=1 with out_data=4 on the next cycle.
  - in_data=16'h0007 -> rejected, no out_valid, reject_cnt=1 (with STATS_EN).
- out_ready=0, push four accepted samples (16'h0001..16'h0004, range_max=255) -> count=4. A fifth sample 16'h0005 is dropped and overflow=1. Draining yields 1,2,3,4.
- FIFO full, and in the same cycle in_valid (16'h0009) plus out_ready=1 -> head popped, 9 enqueued, count stays 4, overflow stays 0.
- 3 entries buffered, pulse cfg_valid with range_max=0 -> next cycle FLUSH (out_valid=0, in_valid ignored). Then RUN: every in_data yields out_data=0 and overflow is cleared.
- In IDLE before any cfg_valid, in_valid pulses -> no output, no count change. Assert rst mid-RUN with 2 entries -> out_valid=0, overflow=0, state IDLE immediately.
- Compile without RAND_SAMPLER_STATS_EN and feed 10 rejected samples -> reject_cnt=0. With the macro defined -> reject_cnt=10.
